// File: rtl/wb_mailbox_pkg.sv
// Shared constants and helpers for the Wishbone mailbox slave: FSM state
// codes, control-register placement after the word array, and byte-lane merge.
package wb_mailbox_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Register indices counted from the first slot after the mailbox words
    localparam int STATUS_OFS = 0;
    localparam int IRQEN_OFS  = 1;

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = lane_mask(strb);
        return (old_word & ~m) | (new_word & m);
    endfunction

endpackage

// File: rtl/wb_mailbox_slave.sv
// Wishbone classic slave exposing a mailbox of 32-bit words; SoC word writes are
// forwarded on mb_tx, remote updates arrive on mb_rx and raise per-word flags.
module wb_mailbox_slave
    import wb_mailbox_pkg::*;
#(
    parameter logic [31:0] pBASE     = 32'h3000_2000,
    parameter logic [31:0] pWIN_MASK = 32'h0000_0FFF,
    parameter int          pDEPTH    = 8,
    parameter int          pIDX_W    = 3
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [31:0]       wbs_adr,
    input  logic [31:0]       wbs_wdata,
    input  logic [3:0]        wbs_sel,
    input  logic              wbs_cyc,
    input  logic              wbs_stb,
    input  logic              wbs_we,
    output logic              wbs_ack,
    output logic [31:0]       wbs_rdata,
    output logic              mb_tx_valid,
    input  logic              mb_tx_ready,
    output logic [pIDX_W-1:0] mb_tx_idx,
    output logic [31:0]       mb_tx_data,
    output logic [3:0]        mb_tx_strb,
    input  logic              mb_rx_valid,
    output logic              mb_rx_ready,
    input  logic [pIDX_W-1:0] mb_rx_idx,
    input  logic [31:0]       mb_rx_data,
    input  logic [3:0]        mb_rx_strb,
    output logic              irq
);

    localparam logic [9:0] WORDS_END  = 10'(pDEPTH);
    localparam logic [9:0] STATUS_REG = 10'(pDEPTH + STATUS_OFS);
    localparam logic [9:0] IRQEN_REG  = 10'(pDEPTH + IRQEN_OFS);

    logic [1:0]        state;
    logic [31:0]       words [pDEPTH];
    logic [pDEPTH-1:0] flags;
    logic [pDEPTH-1:0] irq_en;
    logic              rx_en;

    logic [9:0]        reg_ofs;
    logic [pIDX_W-1:0] widx;
    logic              hit;
    logic              is_word;
    logic              tx_need;
    logic              stall;
    logic              commit;
    logic              word_wr;
    logic              sts_wr;
    logic              en_wr;
    logic              rx_fire;
    logic [31:0]       wr_merged;
    logic [31:0]       clr_word;
    logic [31:0]       en_merged;
    logic [pDEPTH-1:0] flag_set;
    logic [pDEPTH-1:0] flag_clr;
    logic [31:0]       read_val;

    assign reg_ofs = wbs_adr[11:2];
    assign widx    = reg_ofs[pIDX_W-1:0];
    assign hit     = wbs_cyc & wbs_stb & ((wbs_adr & ~pWIN_MASK) == pBASE);
    assign is_word = reg_ofs < WORDS_END;

    // A zero-lane word write carries nothing to forward, so it never waits on the slot
    assign tx_need = wbs_we & is_word & (|wbs_sel);
    assign stall   = tx_need & mb_tx_valid & ~mb_tx_ready;
    assign commit  = hit & ~stall & ((state == ST_IDLE) | (state == ST_WAIT));
    assign word_wr = commit & tx_need;
    assign sts_wr  = commit & wbs_we & (reg_ofs == STATUS_REG);
    assign en_wr   = commit & wbs_we & (reg_ofs == IRQEN_REG);

    // Remote is refused only when the SoC is writing the same word this cycle
    assign mb_rx_ready = rx_en & ~(word_wr & (widx == mb_rx_idx));
    assign rx_fire     = mb_rx_valid & mb_rx_ready;

    assign wr_merged = byte_merge(words[widx], wbs_wdata, wbs_sel);
    assign clr_word  = wbs_wdata & lane_mask(wbs_sel);
    assign en_merged = byte_merge(32'(irq_en), wbs_wdata, wbs_sel);
    assign flag_clr  = sts_wr ? clr_word[pDEPTH-1:0] : '0;
    assign flag_set  = rx_fire ? (pDEPTH'(1) << mb_rx_idx) : '0;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        read_val = '0;
        if (is_word) begin
            read_val = words[widx];
        end else if (reg_ofs == STATUS_REG) begin
            read_val = 32'(flags);
        end else if (reg_ofs == IRQEN_REG) begin
            read_val = 32'(irq_en);
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state     <= ST_IDLE;
            wbs_ack   <= 1'b0;
            wbs_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (!hit) begin
                        state <= ST_IDLE;
                    end else if (stall) begin
                        state <= ST_WAIT;
                    end else begin
                        state     <= ST_ACK;
                        wbs_ack   <= 1'b1;
                        wbs_rdata <= wbs_we ? '0 : read_val;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    wbs_ack   <= 1'b0;
                    wbs_rdata <= '0;
                end
            endcase
        end
    end

    // NOTE: the word array is reset explicitly because reads must return 0 after reset;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            for (int i = 0; i < pDEPTH; i++) begin
                words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pDEPTH; i++) begin
                if (word_wr && (widx == pIDX_W'(i))) begin
                    words[i] <= wr_merged;
                end else if (rx_fire && (mb_rx_idx == pIDX_W'(i))) begin
                    words[i] <= byte_merge(words[i], mb_rx_data, mb_rx_strb);
                end
            end
        end
    end

    // Set beats clear when the remote and a W1C hit the same flag together
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            flags  <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
            rx_en  <= 1'b0;
        end else begin
            flags <= (flags & ~flag_clr) | flag_set;
            if (en_wr) begin
                irq_en <= en_merged[pDEPTH-1:0];
            end
            irq   <= |(flags & irq_en);
            rx_en <= 1'b1;
        end
    end

    // Single holding slot: a new word write is only admitted once this one drains
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            mb_tx_valid <= 1'b0;
            mb_tx_idx   <= '0;
            mb_tx_data  <= '0;
            mb_tx_strb  <= '0;
        end else if (word_wr) begin
            mb_tx_valid <= 1'b1;
            mb_tx_idx   <= widx;
            mb_tx_data  <= wr_merged;
            mb_tx_strb  <= wbs_sel;
        end else if (mb_tx_ready) begin
            mb_tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Directed bench for wb_mailbox_slave: a transaction-level mailbox model checked
// every cycle (read data, ack shape, irq, forwarded writes) plus literal pins.
module tb_wb_mailbox_slave;

    localparam int DEPTH = 8;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic [31:0] wbs_adr = '0;
    logic [31:0] wbs_wdata = '0;
    logic [3:0]  wbs_sel = '0;
    logic        wbs_cyc = 1'b0;
    logic        wbs_stb = 1'b0;
    logic        wbs_we = 1'b0;
    logic        wbs_ack;
    logic [31:0] wbs_rdata;
    logic        mb_tx_valid;
    logic        mb_tx_ready = 1'b1;
    logic [2:0]  mb_tx_idx;
    logic [31:0] mb_tx_data;
    logic [3:0]  mb_tx_strb;
    logic        mb_rx_valid = 1'b0;
    logic        mb_rx_ready;
    logic [2:0]  mb_rx_idx = '0;
    logic [31:0] mb_rx_data = '0;
    logic [3:0]  mb_rx_strb = '0;
    logic        irq;

    wb_mailbox_slave dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
        .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
        .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata),
        .mb_tx_valid(mb_tx_valid), .mb_tx_ready(mb_tx_ready), .mb_tx_idx(mb_tx_idx),
        .mb_tx_data(mb_tx_data), .mb_tx_strb(mb_tx_strb),
        .mb_rx_valid(mb_rx_valid), .mb_rx_ready(mb_rx_ready), .mb_rx_idx(mb_rx_idx),
        .mb_rx_data(mb_rx_data), .mb_rx_strb(mb_rx_strb),
        .irq(irq)
    );

    always #5 wb_clk = ~wb_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural mailbox model ----------------
    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } tx_item_t;

    logic [31:0] m_words [DEPTH];
    logic [7:0]  m_flags;
    logic [7:0]  m_en;
    tx_item_t    tx_q[$];
    logic        rx_pend;
    tx_item_t    rx_item;
    logic        prev_ack;
    logic        irq_prev;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        int ofs;
        ofs = int'(adr[11:2]);
        if (ofs < DEPTH) return m_words[ofs];
        if (ofs == DEPTH) return {24'd0, m_flags};
        if (ofs == DEPTH + 1) return {24'd0, m_en};
        return 32'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_words[i] = '0;
        m_flags = '0;
        m_en = '0;
        tx_q.delete();
        rx_pend = 1'b0;
        prev_ack = 1'b0;
        irq_prev = 1'b0;
    endtask

    initial model_clear();

    // Handshakes are taken from values just before the edge
    always @(posedge wb_clk) begin
        if (wb_rst) begin
            if (mb_rx_valid && mb_rx_ready) begin
                rx_pend = 1'b1;
                rx_item = '{idx: mb_rx_idx, data: mb_rx_data, strb: mb_rx_strb};
            end
            if (mb_tx_valid && mb_tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", {29'd0, mb_tx_idx}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_idx", {29'd0, mb_tx_idx}, {29'd0, tx_q[0].idx});
                    check("tx_data", mb_tx_data, tx_q[0].data);
                    check("tx_strb", {28'd0, mb_tx_strb}, {28'd0, tx_q[0].strb});
                    void'(tx_q.pop_front());
                end
            end
        end
    end

    // Compare process: read data, ack shape, irq lag; then advance the model
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            model_clear();
        end else begin
            check("irq", {31'd0, irq}, {31'd0, irq_prev});
            if (wbs_ack) begin
                check("ack_single_pulse", {31'd0, prev_ack}, 32'd0);
                if (!wbs_we) begin
                    check("rdata", wbs_rdata, model_read(wbs_adr));
                end else begin
                    int ofs;
                    ofs = int'(wbs_adr[11:2]);
                    if (ofs < DEPTH) begin
                        if (wbs_sel != 4'd0) begin
                            m_words[ofs] = merge(m_words[ofs], wbs_wdata, wbs_sel);
                            tx_q.push_back('{idx: ofs[2:0], data: m_words[ofs], strb: wbs_sel});
                        end
                    end else if (ofs == DEPTH) begin
                        m_flags = m_flags & ~(wbs_wdata[7:0] & {8{wbs_sel[0]}});
                    end else if (ofs == DEPTH + 1) begin
                        m_en = m_en & ~{8{wbs_sel[0]}} | (wbs_wdata[7:0] & {8{wbs_sel[0]}});
                    end
                end
            end else begin
                check("rdata_idle_zero", wbs_rdata, 32'd0);
            end
            if (rx_pend) begin
                m_words[rx_item.idx] = merge(m_words[rx_item.idx], rx_item.data, rx_item.strb);
                m_flags[rx_item.idx] = 1'b1;
                rx_pend = 1'b0;
            end
            irq_prev = |(m_flags & m_en);
            prev_ack = wbs_ack;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel,
                           input logic we, input int max_cyc,
                           output logic acked, output int lat, output logic [31:0] rd);
        @(negedge wb_clk); #1;
        wbs_adr = adr; wbs_wdata = data; wbs_sel = sel; wbs_we = we;
        wbs_cyc = 1'b1; wbs_stb = 1'b1;
        acked = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= max_cyc && !acked; i++) begin
            @(negedge wb_clk);
            if (wbs_ack) begin
                acked = 1'b1; lat = i; rd = wbs_rdata;
            end
        end
        #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [31:0] adr, input logic [31:0] data,
                          input logic [3:0] sel);
        logic a; int l; logic [31:0] r;
        wb_xfer(adr, data, sel, 1'b1, 20, a, l, r);
        check({name, "_acked"}, {31'd0, a}, 32'd1);
        check({name, "_latency"}, l, 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic a; int l; logic [31:0] r;
        wb_xfer(adr, 32'd0, 4'hF, 1'b0, 20, a, l, r);
        check({name, "_acked"}, {31'd0, a}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic rx_send(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb,
                           output int attempts);
        @(negedge wb_clk); #1;
        mb_rx_valid = 1'b1; mb_rx_idx = idx; mb_rx_data = data; mb_rx_strb = strb;
        attempts = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge wb_clk);
            if (mb_rx_ready) begin
                attempts = i;
                break;
            end
        end
        @(negedge wb_clk); #1;
        mb_rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a2; int l2; logic [31:0] r2; int att;

        // Reset state
        repeat (3) @(negedge wb_clk);
        check("rst_ack", {31'd0, wbs_ack}, 32'd0);
        check("rst_rdata", wbs_rdata, 32'd0);
        check("rst_tx_valid", {31'd0, mb_tx_valid}, 32'd0);
        check("rst_tx_data", mb_tx_data, 32'd0);
        check("rst_rx_ready", {31'd0, mb_rx_ready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #1 wb_rst = 1'b1;
        @(negedge wb_clk);
        check("rx_ready_after_rst", {31'd0, mb_rx_ready}, 32'd1);

        // Full-word write, forwarded with the merged word
        wr_chk("wr_w0", 32'h3000_2000, 32'hA5A5_A5A5, 4'hF);
        check("tx0_valid", {31'd0, mb_tx_valid}, 32'd1);
        check("tx0_idx", {29'd0, mb_tx_idx}, 32'd0);
        check("tx0_data", mb_tx_data, 32'hA5A5_A5A5);
        check("tx0_strb", {28'd0, mb_tx_strb}, 32'hF);

        rd_chk("rd_w0", 32'h3000_2000, 32'hA5A5_A5A5);
        rd_chk("rd_unmapped", 32'h3000_2FFC, 32'd0);
        wb_xfer(32'h3000_3000, 32'd0, 4'hF, 1'b0, 6, a2, l2, r2);
        check("out_of_window_no_ack", {31'd0, a2}, 32'd0);

        // Partial and zero-lane writes
        wr_chk("wr_w4_partial", 32'h3000_2010, 32'hDEAD_BEEF, 4'b0101);
        rd_chk("rd_w4_partial", 32'h3000_2010, 32'h00AD_00EF);
        wr_chk("wr_w4_sel0", 32'h3000_2010, 32'hFFFF_FFFF, 4'h0);
        rd_chk("rd_w4_sel0", 32'h3000_2010, 32'h00AD_00EF);

        // Back-to-back writes with the remote stalled
        mb_tx_ready = 1'b0;
        fork
            begin
                wr_chk("wr_w1", 32'h3000_2004, 32'h1111_1111, 4'hF);
                wb_xfer(32'h3000_2008, 32'h2222_2222, 4'hF, 1'b1, 40, a2, l2, r2);
            end
            begin
                repeat (10) @(negedge wb_clk);
                #1 mb_tx_ready = 1'b1;
            end
        join
        check("stall_acked", {31'd0, a2}, 32'd1);
        check("stall_held", {31'd0, (l2 >= 5)}, 32'd1);
        repeat (3) @(negedge wb_clk);
        check("tx_order_drained", tx_q.size(), 32'd0);

        // Remote update, flags, irq enable and W1C
        rx_send(3'd3, 32'h1234_5678, 4'b0011, att);
        check("rx3_accepted", att, 32'd1);
        rd_chk("rd_w3", 32'h3000_200C, 32'h0000_5678);
        rd_chk("rd_status", 32'h3000_2020, 32'h0000_0008);
        wr_chk("wr_irq_en", 32'h3000_2024, 32'h0000_0008, 4'hF);
        repeat (2) @(negedge wb_clk);
        check("irq_high", {31'd0, irq}, 32'd1);
        wr_chk("wr_w1c", 32'h3000_2020, 32'h0000_0008, 4'hF);
        repeat (2) @(negedge wb_clk);
        check("irq_low", {31'd0, irq}, 32'd0);
        rd_chk("rd_status_cleared", 32'h3000_2020, 32'd0);

        // Collision on word 2: remote is refused once, then overwrites
        fork
            wr_chk("wr_w2_collide", 32'h3000_2008, 32'hAAAA_AAAA, 4'hF);
            rx_send(3'd2, 32'h5566_7788, 4'hF, att);
        join
        check("collide_rx_attempts", att, 32'd2);
        rd_chk("rd_w2_collide", 32'h3000_2008, 32'h5566_7788);

        // Reset while a write waits on the slot
        mb_tx_ready = 1'b0;
        wr_chk("wr_w5", 32'h3000_2014, 32'h5555_5555, 4'hF);
        @(negedge wb_clk); #1;
        wbs_adr = 32'h3000_2018; wbs_wdata = 32'h6666_6666; wbs_sel = 4'hF;
        wbs_we = 1'b1; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        repeat (3) begin
            @(negedge wb_clk);
            check("wait_no_ack", {31'd0, wbs_ack}, 32'd0);
        end
        #1 wb_rst = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, wbs_ack}, 32'd0);
        check("mid_rst_tx_valid", {31'd0, mb_tx_valid}, 32'd0);
        check("mid_rst_tx_data", mb_tx_data, 32'd0);
        check("mid_rst_rx_ready", {31'd0, mb_rx_ready}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        repeat (2) @(negedge wb_clk);
        #1 wb_rst = 1'b1; mb_tx_ready = 1'b1;
        wr_chk("wr_w6_after_rst", 32'h3000_2018, 32'hCAFE_F00D, 4'hF);
        rd_chk("rd_w6_after_rst", 32'h3000_2018, 32'hCAFE_F00D);
        rd_chk("rd_w5_lost", 32'h3000_2014, 32'd0);
        repeat (3) @(negedge wb_clk);
        check("tx_final_drained", tx_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
